// File: rtl/serial_add_pkg.sv
// Shared constants for the serial adder controller: slice width, FSM encoding
// and the slice-index width helper.
package serial_add_pkg;

  localparam int SLICE_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // A single-slice build still needs a 1-bit index register.
  function automatic int idx_w(input int s);
    return (s <= 1) ? 1 : $clog2(s);
  endfunction

endpackage

// File: rtl/adder5.sv
// 5-bit ripple adder slice, shared by the serial controller as its only datapath.
module adder5 (
  input  logic [4:0] a,
  input  logic [4:0] b,
  input  logic       cin,
  output logic [4:0] sum,
  output logic       cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {5'd0, cin};

endmodule

// File: rtl/serial_add_ctrl.sv
// Wide adder that reuses one adder5 slice, LSB slice first, carry registered between slices.
// Optional SERIAL_ADD_SUB_EN adds a sub port that turns the operation into a - b.
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// RUN   | one slice per cycle through the shared adder5
// DONE  | result held until the consumer takes it
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int S  = WIDTH / SLICE_W;
  localparam int IW = idx_w(S);
  localparam logic [IW-1:0] LAST_IDX = IW'(S - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic [IW-1:0]    idx_q;
  logic             carry_q, cout_q;
  logic [WIDTH-1:0] b_load;
  logic             cin_load;
  logic [SLICE_W-1:0] slice_sum;
  logic             slice_cout;
  logic             last_slice;

`ifdef SERIAL_ADD_SUB_EN
  // Subtraction is a + ~b + 1, so the caller's cin is overridden.
  assign b_load   = sub ? ~b : b;
  assign cin_load = sub ? 1'b1 : cin;
`else
  assign b_load   = b;
  assign cin_load = cin;
`endif

  assign last_slice = (idx_q == LAST_IDX);

  adder5 u_slice (
    .a    (a_q[SLICE_W-1:0]),
    .b    (b_q[SLICE_W-1:0]),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)   state_nxt = RUN;
      RUN:     if (last_slice) state_nxt = DONE;
      DONE:    if (out_ready)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b_load;
            carry_q <= cin_load;
            idx_q   <= '0;
          end
        end
        RUN: begin
          // Operands shift down; each slice result enters at the top of sum,
          // so after S cycles slice 0 has reached bits 4:0.
          a_q     <= a_q >> SLICE_W;
          b_q     <= b_q >> SLICE_W;
          sum_q   <= WIDTH'({slice_sum, sum_q} >> SLICE_W);
          carry_q <= slice_cout;
          idx_q   <= idx_q + IW'(1);
          if (last_slice) cout_q <= slice_cout;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl at WIDTH=20; build with SERIAL_ADD_SUB_EN
// to also exercise subtraction.
module tb_serial_add_ctrl;

  localparam int WIDTH = 20;
  localparam int S     = 4;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
  } res_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             cin = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
  logic             sub = 1'b0;
`endif
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

  int   vectors = 0;
  int   miscompares = 0;
  res_t exp_q[$];

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef SERIAL_ADD_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic res_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                 input logic ci, input logic s);
    logic [WIDTH:0] full;
    res_t r;
    if (s) full = {1'b0, x} + {1'b0, ~y} + (WIDTH+1)'(1);
    else   full = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, ci};
    r.sum  = full[WIDTH-1:0];
    r.cout = full[WIDTH];
    return r;
  endfunction

  // Results are compared in the cycle before the handshake edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check_val("unexpected_result", 64'd1, 64'd0);
      end else begin
        res_t r;
        r = exp_q.pop_front();
        check_val("sum", 64'(sum), 64'(r.sum));
        check_val("cout", 64'(cout), 64'(r.cout));
      end
    end
  end

  task automatic issue(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                       input logic ci, input logic s);
    int n;
    @(negedge clk);
    a = x; b = y; cin = ci;
`ifdef SERIAL_ADD_SUB_EN
    sub = s;
`endif
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check_val("accept_timeout", 64'd0, 64'd1);
    else exp_q.push_back(model(x, y, ci, s));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic finish_op();
    int n;
    out_ready = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (exp_q.size() != 0 && n < 40);
    check_val("drain", 64'(exp_q.size()), 64'd0);
    check_val("in_ready_after_hs", 64'(in_ready), 64'd1);
    check_val("out_valid_after_hs", 64'(out_valid), 64'd0);
    out_ready = 1'b0;
  endtask

  initial begin
    res_t   e;
    int     n;
    time    t_acc[3];
    logic [WIDTH-1:0] ra[3];
    logic [WIDTH-1:0] rb[3];
    logic   rc[3];

    repeat (2) @(negedge clk);
    check_val("rst_in_ready", 64'(in_ready), 64'd1);
    check_val("rst_out_valid", 64'(out_valid), 64'd0);
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_sum", 64'(sum), 64'd0);
    check_val("rst_cout", 64'(cout), 64'd0);
    rst_n = 1'b1;

    // Simple add with exact latency and busy window
    issue(20'h00003, 20'h00004, 1'b0, 1'b0);
    check_val("busy_t0", 64'(busy), 64'd1);
    check_val("in_ready_run", 64'(in_ready), 64'd0);
    for (int i = 1; i <= S; i++) begin
      @(posedge clk);
      #1;
      check_val("latency", 64'(out_valid), 64'(i == S));
    end
    check_val("busy_done", 64'(busy), 64'd1);
    finish_op();
    check_val("busy_after_hs", 64'(busy), 64'd0);

    // Full-width carry, then a carry across one slice boundary
    issue(20'hFFFFF, 20'h00001, 1'b0, 1'b0);
    finish_op();
    issue(20'h0001F, 20'h00001, 1'b0, 1'b0);
    finish_op();

    // Backpressure: result must hold while ignored operands are offered
    issue(20'h12345, 20'h0ABCD, 1'b1, 1'b0);
    e = model(20'h12345, 20'h0ABCD, 1'b1, 1'b0);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_val("bp_out_valid_rise", 64'(out_valid), 64'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = i[0];
      a = 20'h00001;
      b = 20'h00001;
      @(posedge clk);
      #1;
      check_val("bp_out_valid", 64'(out_valid), 64'd1);
      check_val("bp_in_ready", 64'(in_ready), 64'd0);
      check_val("bp_sum", 64'(sum), 64'(e.sum));
      check_val("bp_cout", 64'(cout), 64'(e.cout));
    end
    in_valid = 1'b0;
    finish_op();
    check_val("bp_no_capture", 64'(busy), 64'd0);

    // Reset during the second RUN cycle aborts the operation
    @(negedge clk);
    a = 20'h0F0F0; b = 20'h0F0F0; cin = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check_val("pre_rst_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check_val("mid_rst_sum", 64'(sum), 64'd0);
    check_val("mid_rst_in_ready", 64'(in_ready), 64'd1);
    check_val("mid_rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(20'h00005, 20'h00006, 1'b1, 1'b0);
    finish_op();

    // Back-to-back with in_valid and out_ready held high
    for (int k = 0; k < 3; k++) begin
      ra[k] = WIDTH'($urandom);
      rb[k] = WIDTH'($urandom);
      rc[k] = 1'($urandom_range(0, 1));
    end
    out_ready = 1'b1;
    @(negedge clk);
    a = ra[0]; b = rb[0]; cin = rc[0];
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      while (!in_ready && n < 30) begin
        @(negedge clk);
        n++;
      end
      if (!in_ready) check_val("b2b_accept_timeout", 64'd0, 64'd1);
      else exp_q.push_back(model(ra[k], rb[k], rc[k], 1'b0));
      @(posedge clk);
      t_acc[k] = $time;
      #1;
      if (k < 2) begin
        a = ra[k+1]; b = rb[k+1]; cin = rc[k+1];
      end else begin
        in_valid = 1'b0;
      end
      if (k > 0) check_val("issue_interval", 64'((t_acc[k] - t_acc[k-1]) / 10), 64'(S + 2));
    end
    finish_op();

`ifdef SERIAL_ADD_SUB_EN
    issue(20'h00010, 20'h00001, 1'b0, 1'b1);
    finish_op();
    issue(20'h00000, 20'h00001, 1'b0, 1'b1);
    finish_op();
    issue(20'h00123, 20'h00023, 1'b1, 1'b1);
    finish_op();
    sub = 1'b0;
`endif

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
